imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader_byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package : imem_loader_pkg -- shared FSM encoding and stream framing constants
// Rev     : 1.0
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN0  = 3'd0,
        ST_LEN1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERR   = 3'd6
    } loader_state_t;

    localparam int c_HDR_BYTES = 2;

    function automatic int bytesPerWord(input int dataW);
        return dataW / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : imem_loader_if -- byte-stream handshake plus IRAM write port
// Rev       : 1.0
// ============================================================================
interface imem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wren;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_din, mem_wren
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_din, mem_wren
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module : imem_loader_byte_packer -- little-endian byte lanes into one word
// Rev    : 1.0
// ============================================================================
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_byteEn,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_wordDone
);

    localparam int c_BPW    = bytesPerWord(DATA_W);
    localparam int c_LANE_W = (c_BPW > 1) ? $clog2(c_BPW) : 1;
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_BPW - 1);

    logic [c_LANE_W-1:0] r_lane;
    logic [DATA_W-1:0]   r_word;

    // Combinational: the current transfer fills the top lane.
    assign o_wordDone = i_byteEn && (r_lane == c_LAST_LANE);
    assign o_word     = r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_lane <= '0;
        end else if (i_byteEn) begin
            r_word[8*r_lane +: 8] <= i_byte;
            r_lane <= o_wordDone ? '0 : r_lane + c_LANE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_loader -- holds the core in clear while streaming a program
//          into IRAM. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
// Rev    : 1.0
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         core_clear,
    output logic         busy,
    output logic         error,
    output logic [15:0]  words_loaded
);

    localparam logic [16:0] c_DEPTH_LEN = 17'(DEPTH);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t c_DONE_STATE = ST_CHK;
`else
    localparam loader_state_t c_DONE_STATE = ST_RUN;
`endif

    loader_state_t     r_state;
    loader_state_t     w_stateNext;
    logic [15:0]       r_length;
    logic [15:0]       r_wordsLoaded;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rxReady;
    logic              r_memWren;
    logic              r_coreClear;
    logic              r_busy;
    logic              r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_chk;
`endif

    logic              w_xfer;
    logic              w_restart;
    logic              w_lastWord;
    logic [15:0]       w_lenFull;
    logic              w_packDone;
    logic [DATA_W-1:0] w_packWord;

    assign w_xfer     = bus.rx_valid && r_rxReady;
    assign w_restart  = start && ((r_state == ST_RUN) || (r_state == ST_ERR));
    assign w_lastWord = (r_wordsLoaded + 16'd1) == r_length;
    assign w_lenFull  = {bus.rx_data, r_length[7:0]};

    imem_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clock),
        .rst_n      (clear),
        .i_clr      (r_state == ST_LEN1),
        .i_byteEn   (w_xfer && (r_state == ST_DATA)),
        .i_byte     (bus.rx_data),
        .o_word     (w_packWord),
        .o_wordDone (w_packDone)
    );

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_LEN0:  if (w_xfer) w_stateNext = ST_LEN1;
            ST_LEN1: begin
                if (w_xfer) begin
                    if ({1'b0, w_lenFull} > c_DEPTH_LEN) w_stateNext = ST_ERR;
                    else if (w_lenFull == 16'd0)         w_stateNext = c_DONE_STATE;
                    else                                 w_stateNext = ST_DATA;
                end
            end
            ST_DATA:  if (w_packDone) w_stateNext = ST_WRITE;
            ST_WRITE: w_stateNext = w_lastWord ? c_DONE_STATE : ST_DATA;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK:   if (w_xfer) w_stateNext = (bus.rx_data == r_chk) ? ST_RUN : ST_ERR;
`endif
            ST_RUN:   if (start) w_stateNext = ST_LEN0;
            ST_ERR:   if (start) w_stateNext = ST_LEN0;
            default:  w_stateNext = ST_LEN0;
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the FSM.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state       <= ST_LEN0;
            r_rxReady     <= 1'b0;
            r_memWren     <= 1'b0;
            r_coreClear   <= 1'b0;
            r_busy        <= 1'b1;
            r_error       <= 1'b0;
            r_length      <= '0;
            r_wordsLoaded <= '0;
            r_addr        <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_rxReady   <= w_stateNext inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CHK};
            r_busy      <= w_stateNext inside {ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE, ST_CHK};
            r_memWren   <= (w_stateNext == ST_WRITE);
            r_coreClear <= (w_stateNext == ST_RUN);
            r_error     <= (w_stateNext == ST_ERR);
            case (r_state)
                ST_LEN0:  if (w_xfer) r_length[7:0]  <= bus.rx_data;
                ST_LEN1:  if (w_xfer) r_length[15:8] <= bus.rx_data;
                ST_WRITE: begin
                    r_wordsLoaded <= r_wordsLoaded + 16'd1;
                    // Address stays on the final word so it never wraps.
                    if (!w_lastWord) r_addr <= r_addr + ADDR_W'(1);
                end
                default: begin
                    if (w_restart) begin
                        r_length      <= '0;
                        r_wordsLoaded <= '0;
                        r_addr        <= '0;
                    end
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)         r_chk <= '0;
        else if (w_restart) r_chk <= '0;
        else if (w_xfer)    r_chk <= r_chk ^ bus.rx_data;
    end
`endif

    assign bus.rx_ready  = r_rxReady;
    assign bus.mem_wren  = r_memWren;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_din   = w_packWord;
    assign core_clear    = r_coreClear;
    assign busy          = r_busy;
    assign error         = r_error;
    assign words_loaded  = r_wordsLoaded;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_imem_loader -- directed self-checking bench for imem_loader
// Rev    : 1.0
// ============================================================================
module tb_imem_loader;

    logic        clock;
    logic        clear;
    logic        start;
    logic        core_clear;
    logic        busy;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader_if #(.DATA_W(32), .ADDR_W(8)) bus ();

    imem_loader #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .bus          (bus),
        .core_clear   (core_clear),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          wrCnt  = 0;
    int          rdyViol = 0;
    bit          armed  = 0;
    logic [7:0]  wrAddr [0:15];
    logic [31:0] wrData [0:15];
    logic [31:0] iram   [0:255];
    logic [7:0]  txq [$];

    // IRAM model and write log; also flags rx_ready outside the WRITE-only low window.
    always @(negedge clock) begin
        if (bus.mem_wren === 1'b1) begin
            iram[bus.mem_addr] = bus.mem_din;
            if (wrCnt < 16) begin
                wrAddr[wrCnt] = bus.mem_addr;
                wrData[wrCnt] = bus.mem_din;
            end
            wrCnt++;
        end
        if (armed) begin
            if (bus.mem_wren && bus.rx_ready) rdyViol++;
            if (!bus.mem_wren && busy && !bus.rx_ready) rdyViol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit ok = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clock);
            if (bus.rx_ready === 1'b1) ok = 1;
        end
        if (!ok) check("rx_accept_timeout", {31'b0, bus.rx_ready}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic sendQueue(input bit gaps);
        foreach (txq[i]) begin
            if (gaps) begin
                bus.rx_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clock);
                #1;
            end
            sendByte(txq[i]);
            armed = 1;
        end
        bus.rx_valid = 1'b0;
        txq.delete();
    endtask

    task automatic waitRun(input string tag);
        for (int n = 0; n < 20 && core_clear !== 1'b1; n++) @(negedge clock);
        check(tag, {31'b0, core_clear}, 32'd1);
    endtask

    task automatic doReset();
        armed = 0;
        bus.rx_valid = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        #1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        wrCnt = 0;
    endtask

    initial begin
        clear = 1'b1;
        start = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 256; i++) iram[i] = 32'h0;
        #2;

        // ---- reset values and the basic 2-word load ----
        clear = 1'b0;
        #1;
        check("rst_rx_ready",   {31'b0, bus.rx_ready}, 32'd0);
        check("rst_busy",       {31'b0, busy},         32'd1);
        check("rst_core_clear", {31'b0, core_clear},   32'd0);
        check("rst_error",      {31'b0, error},        32'd0);
        check("rst_mem_wren",   {31'b0, bus.mem_wren}, 32'd0);
        check("rst_mem_addr",   {24'b0, bus.mem_addr}, 32'd0);
        check("rst_mem_din",    bus.mem_din,           32'd0);
        check("rst_words",      {16'b0, words_loaded}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        wrCnt = 0;
        #1;
        check("rel_rx_ready_low", {31'b0, bus.rx_ready}, 32'd0);
        @(posedge clock); #1;
        check("rel_rx_ready_high", {31'b0, bus.rx_ready}, 32'd1);

        txq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        sendQueue(1'b0);
        check("w2_wren",       {31'b0, bus.mem_wren}, 32'd1);
        check("w2_addr",       {24'b0, bus.mem_addr}, 32'd1);
        check("w2_din",        bus.mem_din,           32'h0010_0093);
        check("w2_rx_ready",   {31'b0, bus.rx_ready}, 32'd0);
        check("w2_core_clear", {31'b0, core_clear},   32'd0);
`ifdef LOADER_CHECKSUM_EN
        sendByte(8'h92);
`else
        @(posedge clock); #1;
`endif
        check("t1_core_clear", {31'b0, core_clear},   32'd1);
        check("t1_busy",       {31'b0, busy},         32'd0);
        check("t1_words",      {16'b0, words_loaded}, 32'd2);
        check("t1_wren_low",   {31'b0, bus.mem_wren}, 32'd0);
        check("t1_addr_hold",  {24'b0, bus.mem_addr}, 32'd1);
        check("t1_wr_count",   wrCnt,                 32'd2);
        check("t1_wr0_addr",   {24'b0, wrAddr[0]},    32'd0);
        check("t1_wr0_data",   wrData[0],             32'h0000_0013);
        check("t1_wr1_addr",   {24'b0, wrAddr[1]},    32'd1);
        check("t1_wr1_data",   wrData[1],             32'h0010_0093);
        check("t1_rdy_window", rdyViol,               32'd0);

        // ---- zero-length load ----
        doReset();
`ifdef LOADER_CHECKSUM_EN
        txq = '{8'h00, 8'h00, 8'h00};
`else
        txq = '{8'h00, 8'h00};
`endif
        sendQueue(1'b0);
        check("t2_core_clear", {31'b0, core_clear},   32'd1);
        check("t2_busy",       {31'b0, busy},         32'd0);
        check("t2_error",      {31'b0, error},        32'd0);
        check("t2_no_write",   wrCnt,                 32'd0);
        check("t2_words",      {16'b0, words_loaded}, 32'd0);

        // ---- oversize header 257 ----
        doReset();
        txq = '{8'h01, 8'h01};
        sendQueue(1'b0);
        check("t3_error",      {31'b0, error},        32'd1);
        check("t3_core_clear", {31'b0, core_clear},   32'd0);
        check("t3_rx_ready",   {31'b0, bus.rx_ready}, 32'd0);
        check("t3_busy",       {31'b0, busy},         32'd0);
        repeat (3) @(posedge clock); #1;
        check("t3_error_hold", {31'b0, error},        32'd1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("t3_start_error", {31'b0, error},       32'd0);
        check("t3_start_busy",  {31'b0, busy},        32'd1);

        // ---- 4-word load, gap-free then with random rx_valid gaps ----
        for (int pass = 0; pass < 2; pass++) begin
            doReset();
            for (int i = 0; i < 4; i++) iram[i] = 32'h0;
            rdyViol = 0;
            txq = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                    8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
            txq.push_back(8'hEA);
`endif
            sendQueue(pass == 1);
            waitRun("t4_run");
            check("t4_iram0",    iram[0],               32'h4433_2211);
            check("t4_iram1",    iram[1],               32'h8877_6655);
            check("t4_iram2",    iram[2],               32'hCCBB_AA99);
            check("t4_iram3",    iram[3],               32'hEFBE_ADDE);
            check("t4_wr_count", wrCnt,                 32'd4);
            check("t4_words",    {16'b0, words_loaded}, 32'd4);
            check("t4_addr",     {24'b0, bus.mem_addr}, 32'd3);
            check("t4_rdy_window", rdyViol,             32'd0);
        end

        // ---- asynchronous reset in the middle of a word ----
        doReset();
        txq = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sendQueue(1'b0);
        check("t5_pre_words", {16'b0, words_loaded}, 32'd1);
        armed = 0;
        clear = 1'b0;
        #1;
        check("t5_rx_ready",   {31'b0, bus.rx_ready}, 32'd0);
        check("t5_busy",       {31'b0, busy},         32'd1);
        check("t5_core_clear", {31'b0, core_clear},   32'd0);
        check("t5_error",      {31'b0, error},        32'd0);
        check("t5_mem_wren",   {31'b0, bus.mem_wren}, 32'd0);
        check("t5_mem_addr",   {24'b0, bus.mem_addr}, 32'd0);
        check("t5_mem_din",    bus.mem_din,           32'd0);
        check("t5_words",      {16'b0, words_loaded}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        wrCnt = 0;
        txq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
        txq.push_back(8'h09);
`endif
        sendQueue(1'b0);
        waitRun("t5_run");
        check("t5_wr_count", wrCnt,              32'd1);
        check("t5_wr_addr",  {24'b0, wrAddr[0]}, 32'd0);
        check("t5_wr_data",  wrData[0],          32'h1234_5678);

`ifdef LOADER_CHECKSUM_EN
        // ---- trailing checksum good / bad ----
        doReset();
        txq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        sendQueue(1'b0);
        check("t6_good_run",   {31'b0, core_clear}, 32'd1);
        check("t6_good_error", {31'b0, error},      32'd0);
        check("t6_good_iram",  iram[0],             32'hDDCC_BBAA);
        doReset();
        iram[0] = 32'h0;
        txq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        sendQueue(1'b0);
        check("t6_bad_error", {31'b0, error},      32'd1);
        check("t6_bad_clear", {31'b0, core_clear}, 32'd0);
        check("t6_bad_wr",    wrCnt,               32'd1);
        check("t6_bad_iram",  iram[0],             32'hDDCC_BBAA);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
